// File: rtl/blake2b_msg_bank_pkg.sv
// Shared types and constants for the BLAKE2b message-word bank.
// Optional build macro BLAKE2B_MSG_PINGPONG_EN is consumed by blake2b_msg_bank.
package blake2b_msg_bank_pkg;

  localparam int unsigned Word_Width   = 64;
  localparam int unsigned MIndex_Width = 4;
  localparam int unsigned MsgWords     = 16;

  typedef logic [Word_Width-1:0]   Word_Bus;
  typedef logic [MIndex_Width-1:0] MIndex_Bus;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  function automatic logic is_last_idx(input MIndex_Bus idx);
    return idx == MIndex_Bus'(MsgWords - 1);
  endfunction

endpackage

// File: rtl/blake2b_msg_mux.sv
// One zero-latency 16:1 read port selecting a 64-bit message word by index.
module blake2b_msg_mux
  import blake2b_msg_bank_pkg::*;
(
  input  Word_Bus   words_i [MsgWords],
  input  MIndex_Bus idx_i,
  output Word_Bus   word_o
);

  always_comb begin
    word_o = words_i[idx_i];
  end

endmodule

// File: rtl/blake2b_msg_bank.sv
// Message-word store for the BLAKE2b compress datapath: loads 16 words, serves NUM_PORTS reads.
// Build macro BLAKE2B_MSG_PINGPONG_EN selects a two-bank overlapped-load variant.
module blake2b_msg_bank
  import blake2b_msg_bank_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [Word_Width-1:0]             s_data,
  input  logic                              s_last,
  output logic                              blk_valid,
  input  logic                              blk_release,
  input  logic [NUM_PORTS*MIndex_Width-1:0] mindex_bus_i,
  output logic [NUM_PORTS*Word_Width-1:0]   m_bus_o,
  output logic                              len_err_o
);

  MIndex_Bus wr_cnt_q;
  logic      len_err_q;
  logic      fire;
  logic      last_word;
  Word_Bus   rd_words [MsgWords];

  assign fire      = s_valid && s_ready;
  assign last_word = is_last_idx(wr_cnt_q);
  assign len_err_o = len_err_q;

  // Completion follows wr_cnt alone; s_last only feeds the mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= fire && (s_last != last_word);
      if (fire) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

`ifdef BLAKE2B_MSG_PINGPONG_EN

  Word_Bus    bank_q [2][MsgWords];
  logic       wr_sel_q;
  logic       rd_sel_q;
  logic [1:0] full_q;
  logic [1:0] full_d;
  logic       do_release;

  assign s_ready    = !full_q[wr_sel_q];
  assign blk_valid  = full_q[rd_sel_q];
  assign do_release = blk_release && blk_valid;

  // Completion and release always target different banks, so both apply.
  always_comb begin
    full_d = full_q;
    if (fire && last_word) begin
      full_d[wr_sel_q] = 1'b1;
    end
    if (do_release) begin
      full_d[rd_sel_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < MsgWords; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= '0;
    end else begin
      full_q <= full_d;
      if (fire) begin
        bank_q[wr_sel_q][wr_cnt_q] <= s_data;
      end
      if (fire && last_word) begin
        wr_sel_q <= ~wr_sel_q;
      end
      if (do_release) begin
        rd_sel_q <= ~rd_sel_q;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < MsgWords; i++) begin
      rd_words[i] = bank_q[rd_sel_q][i];
    end
  end

`else

  Word_Bus bank_q [MsgWords];
  state_e  state_q;
  state_e  state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    blk_valid = 1'b0;
    case (state_q)
      EMPTY: begin
        s_ready = 1'b1;
        if (s_valid && last_word) begin
          state_d = FULL;
        end
      end
      FULL: begin
        blk_valid = 1'b1;
        if (blk_release) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MsgWords; i++) begin
        bank_q[i] <= '0;
      end
    end else if (fire) begin
      bank_q[wr_cnt_q] <= s_data;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < MsgWords; i++) begin
      rd_words[i] = bank_q[i];
    end
  end

`endif

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_port
    blake2b_msg_mux u_mux (
      .words_i (rd_words),
      .idx_i   (mindex_bus_i[MIndex_Width*j +: MIndex_Width]),
      .word_o  (m_bus_o[Word_Width*j +: Word_Width])
    );
  end

endmodule
